// File: rtl/decode_npc_pipe.sv
// Decode-stage next-PC unit: resolves branches/jumps from forwarded operands,
// extends immediates, and holds the D/E pipeline register plus perf counters.
module decode_npc_pipe #(
  parameter int XLEN       = 32,
  parameter int DELAY_SLOT = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              e_flush,
  input  logic [XLEN-1:0]   f_pc,
  input  logic [XLEN-1:0]   d_pc,
  input  logic [31:0]       d_ins,
  input  logic [XLEN-1:0]   d_rs_fw,
  input  logic [XLEN-1:0]   d_rt_fw,
  output logic [4:0]        d_rs,
  output logic [4:0]        d_rt,
  output logic              d_branch_true,
  output logic [XLEN-1:0]   npc,
  output logic              f_flush,
  output logic [XLEN-1:0]   e_pc,
  output logic [31:0]       e_ins,
  output logic [XLEN-1:0]   e_rs_data,
  output logic [XLEN-1:0]   e_rt_data,
  output logic [XLEN-1:0]   e_ext,
  output logic [XLEN-1:0]   e_link,
  output logic              e_branch_true,
  output logic [CNT_W-1:0]  taken_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [XLEN-1:0] LINK_OFS = (DELAY_SLOT != 0) ? XLEN'(8) : XLEN'(4);

  logic [5:0]      op_s;
  logic [5:0]      fn_s;
  logic [4:0]      rt_field_s;
  logic [15:0]     imm_s;
  logic [XLEN-1:0] sext_imm_s;
  logic [XLEN-1:0] br_target_s;
  logic [XLEN-1:0] j_target_s;
  logic [XLEN-1:0] target_s;
  logic [XLEN-1:0] ext_s;
  logic [XLEN-1:0] link_s;
  logic            rs_eq_s;
  logic            rs_neg_s;
  logic            rs_zero_s;
  logic            is_branch_s;
  logic            is_jump_s;
  logic            cond_s;
  logic            redirect_s;

  logic [XLEN-1:0]  e_pc_d, e_pc_q;
  logic [31:0]      e_ins_d, e_ins_q;
  logic [XLEN-1:0]  e_rs_d, e_rs_q;
  logic [XLEN-1:0]  e_rt_d, e_rt_q;
  logic [XLEN-1:0]  e_ext_d, e_ext_q;
  logic [XLEN-1:0]  e_link_d, e_link_q;
  logic             e_bt_d, e_bt_q;
  logic [CNT_W-1:0] taken_cnt_d, taken_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

  assign op_s        = d_ins[31:26];
  assign fn_s        = d_ins[5:0];
  assign rt_field_s  = d_ins[20:16];
  assign imm_s       = d_ins[15:0];
  assign d_rs        = d_ins[25:21];
  assign d_rt        = d_ins[20:16];
  assign sext_imm_s  = {{(XLEN-16){imm_s[15]}}, imm_s};
  assign br_target_s = d_pc + XLEN'(4) + {sext_imm_s[XLEN-3:0], 2'b00};
  assign j_target_s  = {d_pc[XLEN-1:28], d_ins[25:0], 2'b00};
  assign link_s      = d_pc + LINK_OFS;

  // Signed compares against zero only need the sign bit and a zero test.
  assign rs_eq_s   = (d_rs_fw == d_rt_fw);
  assign rs_neg_s  = d_rs_fw[XLEN-1];
  assign rs_zero_s = (d_rs_fw == '0);

  // Instruction class, branch condition and redirect target
  always_comb begin
    is_branch_s = 1'b0;
    is_jump_s   = 1'b0;
    cond_s      = 1'b0;
    target_s    = br_target_s;
    case (op_s)
      6'b000100: begin is_branch_s = 1'b1; cond_s = rs_eq_s; end
      6'b000101: begin is_branch_s = 1'b1; cond_s = !rs_eq_s; end
      6'b000110: begin is_branch_s = 1'b1; cond_s = rs_neg_s || rs_zero_s; end
      6'b000111: begin is_branch_s = 1'b1; cond_s = !rs_neg_s && !rs_zero_s; end
      6'b000001: begin
        if (rt_field_s == 5'b00000) begin
          is_branch_s = 1'b1;
          cond_s      = rs_neg_s;
        end else if (rt_field_s == 5'b00001) begin
          is_branch_s = 1'b1;
          cond_s      = !rs_neg_s;
        end else begin
          is_branch_s = 1'b0;
        end
      end
      6'b000010, 6'b000011: begin
        is_jump_s = 1'b1;
        target_s  = j_target_s;
      end
      6'b000000: begin
        if (fn_s == 6'b001000 || fn_s == 6'b001001) begin
          is_jump_s = 1'b1;
          target_s  = d_rs_fw;
        end else begin
          is_jump_s = 1'b0;
        end
      end
      default: begin
        is_branch_s = 1'b0;
      end
    endcase
  end

  assign d_branch_true = is_branch_s && cond_s;
  assign redirect_s    = !stall && (d_branch_true || is_jump_s);
  assign f_flush       = (DELAY_SLOT == 0) ? redirect_s : 1'b0;

  // Next fetch PC selection
  always_comb begin
    npc = f_pc + XLEN'(4);
    if (stall) begin
      npc = f_pc;
    end else if (redirect_s) begin
      npc = target_s;
    end else begin
      npc = f_pc + XLEN'(4);
    end
  end

  // Immediate extension
  always_comb begin
    ext_s = sext_imm_s;
    case (op_s)
      6'b001100, 6'b001101, 6'b001110: ext_s = {{(XLEN-16){1'b0}}, imm_s};
      6'b001111:                       ext_s = {sext_imm_s[XLEN-17:0], 16'h0000};
      default:                         ext_s = sext_imm_s;
    endcase
  end

  // D/E register next state (bubble on flush or stall) and saturating counters
  always_comb begin
    e_pc_d   = d_pc;
    e_ins_d  = d_ins;
    e_rs_d   = d_rs_fw;
    e_rt_d   = d_rt_fw;
    e_ext_d  = ext_s;
    e_link_d = link_s;
    e_bt_d   = d_branch_true;
    if (e_flush || stall) begin
      e_pc_d   = '0;
      e_ins_d  = 32'h0000_0000;
      e_rs_d   = '0;
      e_rt_d   = '0;
      e_ext_d  = '0;
      e_link_d = '0;
      e_bt_d   = 1'b0;
    end else begin
      e_bt_d   = d_branch_true;
    end
    taken_cnt_d = taken_cnt_q;
    if (redirect_s && (taken_cnt_q != '1)) begin
      taken_cnt_d = taken_cnt_q + CNT_W'(1);
    end else begin
      taken_cnt_d = taken_cnt_q;
    end
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      e_pc_q      <= '0;
      e_ins_q     <= 32'h0000_0000;
      e_rs_q      <= '0;
      e_rt_q      <= '0;
      e_ext_q     <= '0;
      e_link_q    <= '0;
      e_bt_q      <= 1'b0;
      taken_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      e_pc_q      <= e_pc_d;
      e_ins_q     <= e_ins_d;
      e_rs_q      <= e_rs_d;
      e_rt_q      <= e_rt_d;
      e_ext_q     <= e_ext_d;
      e_link_q    <= e_link_d;
      e_bt_q      <= e_bt_d;
      taken_cnt_q <= taken_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign e_pc          = e_pc_q;
  assign e_ins         = e_ins_q;
  assign e_rs_data     = e_rs_q;
  assign e_rt_data     = e_rt_q;
  assign e_ext         = e_ext_q;
  assign e_link        = e_link_q;
  assign e_branch_true = e_bt_q;
  assign taken_cnt     = taken_cnt_q;
  assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_decode_npc_pipe.sv
// Randomized bench for decode_npc_pipe: two configurations (32-bit delay-slot,
// 64-bit no-delay-slot with 4-bit counters) share stimulus, checked against a model.
module tb_decode_npc_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, stall, e_flush;
  logic [63:0] f_pc, d_pc, rs_fw, rt_fw;
  logic [31:0] d_ins;

  logic [4:0]  a_rs, a_rt, b_rs, b_rt;
  logic        a_bt, a_ff, a_ebt, b_bt, b_ff, b_ebt;
  logic [31:0] a_npc, a_epc, a_eins, a_ers, a_ert, a_eext, a_elink;
  logic [63:0] b_npc, b_epc, b_ers, b_ert, b_eext, b_elink;
  logic [31:0] b_eins;
  logic [15:0] a_tc, a_sc;
  logic [3:0]  b_tc, b_sc;

  decode_npc_pipe #(.XLEN(32), .DELAY_SLOT(1), .CNT_W(16)) u_a (
    .clk(clk), .reset(reset), .stall(stall), .e_flush(e_flush),
    .f_pc(f_pc[31:0]), .d_pc(d_pc[31:0]), .d_ins(d_ins),
    .d_rs_fw(rs_fw[31:0]), .d_rt_fw(rt_fw[31:0]),
    .d_rs(a_rs), .d_rt(a_rt), .d_branch_true(a_bt), .npc(a_npc), .f_flush(a_ff),
    .e_pc(a_epc), .e_ins(a_eins), .e_rs_data(a_ers), .e_rt_data(a_ert),
    .e_ext(a_eext), .e_link(a_elink), .e_branch_true(a_ebt),
    .taken_cnt(a_tc), .stall_cnt(a_sc));

  decode_npc_pipe #(.XLEN(64), .DELAY_SLOT(0), .CNT_W(4)) u_b (
    .clk(clk), .reset(reset), .stall(stall), .e_flush(e_flush),
    .f_pc(f_pc), .d_pc(d_pc), .d_ins(d_ins),
    .d_rs_fw(rs_fw), .d_rt_fw(rt_fw),
    .d_rs(b_rs), .d_rt(b_rt), .d_branch_true(b_bt), .npc(b_npc), .f_flush(b_ff),
    .e_pc(b_epc), .e_ins(b_eins), .e_rs_data(b_ers), .e_rt_data(b_ert),
    .e_ext(b_eext), .e_link(b_elink), .e_branch_true(b_ebt),
    .taken_cnt(b_tc), .stall_cnt(b_sc));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  typedef struct {
    logic [63:0] npc;
    logic [63:0] ext;
    logic [63:0] link;
    bit          ff;
    bit          bt;
    bit          redir;
  } comb_t;

  // Model state per configuration: index 0 = 32-bit/DS=1, index 1 = 64-bit/DS=0
  logic [63:0] m_epc[2], m_eins[2], m_ers[2], m_ert[2], m_eext[2], m_elink[2];
  bit          m_ebt[2];
  int          m_tc[2], m_sc[2];
  int          cmax[2] = '{65535, 15};

  function automatic logic [63:0] mask_of(input int i);
    return (i == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  function automatic comb_t ref_comb(input int i);
    comb_t  r;
    logic [63:0] m = mask_of(i);
    longint rs, rt, imm, tgt;
    bit     br, cond, jmp;
    int     ds = (i == 0) ? 1 : 0;
    rs  = (i == 1) ? longint'(rs_fw) : longint'(signed'(rs_fw[31:0]));
    rt  = (i == 1) ? longint'(rt_fw) : longint'(signed'(rt_fw[31:0]));
    imm = longint'(signed'(d_ins[15:0]));
    br = 1'b0; cond = 1'b0; jmp = 1'b0; tgt = 0;
    case (d_ins[31:26])
      6'd4: begin br = 1'b1; cond = (rs == rt); end
      6'd5: begin br = 1'b1; cond = (rs != rt); end
      6'd6: begin br = 1'b1; cond = (rs <= 0); end
      6'd7: begin br = 1'b1; cond = (rs > 0); end
      6'd1: begin
        if (d_ins[20:16] == 5'd0) begin br = 1'b1; cond = (rs < 0); end
        else if (d_ins[20:16] == 5'd1) begin br = 1'b1; cond = (rs >= 0); end
      end
      6'd2, 6'd3: begin
        jmp = 1'b1;
        tgt = longint'(d_pc & ~64'h0000_0000_0FFF_FFFF) | (longint'(d_ins[25:0]) * 4);
      end
      6'd0: if (d_ins[5:0] == 6'd8 || d_ins[5:0] == 6'd9) begin jmp = 1'b1; tgt = rs; end
      default: ;
    endcase
    if (br) tgt = longint'(d_pc) + 4 + imm * 4;
    r.bt    = br && cond;
    r.redir = !stall && (r.bt || jmp);
    r.npc   = stall ? (f_pc & m) : (r.redir ? (64'(tgt) & m) : ((f_pc + 64'd4) & m));
    r.ff    = (ds == 0) && r.redir;
    case (d_ins[31:26])
      6'd12, 6'd13, 6'd14: r.ext = 64'(d_ins[15:0]);
      6'd15:               r.ext = 64'(imm * 65536) & m;
      default:             r.ext = 64'(imm) & m;
    endcase
    r.link = (d_pc + ((ds != 0) ? 64'd8 : 64'd4)) & m;
    return r;
  endfunction

  task automatic step();
    comb_t c[2];
    for (int i = 0; i < 2; i++) c[i] = ref_comb(i);
    #2;
    check_eq("a_npc", 64'(a_npc), c[0].npc);
    check_eq("a_f_flush", 64'(a_ff), 64'(c[0].ff));
    check_eq("a_branch_true", 64'(a_bt), 64'(c[0].bt));
    check_eq("a_d_rs", 64'(a_rs), 64'(d_ins[25:21]));
    check_eq("b_npc", b_npc, c[1].npc);
    check_eq("b_f_flush", 64'(b_ff), 64'(c[1].ff));
    check_eq("b_branch_true", 64'(b_bt), 64'(c[1].bt));
    check_eq("b_d_rt", 64'(b_rt), 64'(d_ins[20:16]));
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_epc[i] = '0; m_eins[i] = '0; m_ers[i] = '0; m_ert[i] = '0;
        m_eext[i] = '0; m_elink[i] = '0; m_ebt[i] = 1'b0; m_tc[i] = 0; m_sc[i] = 0;
      end else begin
        if (e_flush || stall) begin
          m_epc[i] = '0; m_eins[i] = '0; m_ers[i] = '0; m_ert[i] = '0;
          m_eext[i] = '0; m_elink[i] = '0; m_ebt[i] = 1'b0;
        end else begin
          m_epc[i] = d_pc & mask_of(i); m_eins[i] = 64'(d_ins);
          m_ers[i] = rs_fw & mask_of(i); m_ert[i] = rt_fw & mask_of(i);
          m_eext[i] = c[i].ext; m_elink[i] = c[i].link; m_ebt[i] = c[i].bt;
        end
        if (c[i].redir && m_tc[i] < cmax[i]) m_tc[i]++;
        if (stall && m_sc[i] < cmax[i]) m_sc[i]++;
      end
    end
    check_eq("a_e_pc", 64'(a_epc), m_epc[0]);
    check_eq("a_e_ins", 64'(a_eins), m_eins[0]);
    check_eq("a_e_rs", 64'(a_ers), m_ers[0]);
    check_eq("a_e_rt", 64'(a_ert), m_ert[0]);
    check_eq("a_e_ext", 64'(a_eext), m_eext[0]);
    check_eq("a_e_link", 64'(a_elink), m_elink[0]);
    check_eq("a_e_bt", 64'(a_ebt), 64'(m_ebt[0]));
    check_eq("a_taken", 64'(a_tc), 64'(m_tc[0]));
    check_eq("a_stall", 64'(a_sc), 64'(m_sc[0]));
    check_eq("b_e_pc", b_epc, m_epc[1]);
    check_eq("b_e_ins", 64'(b_eins), m_eins[1]);
    check_eq("b_e_rs", b_ers, m_ers[1]);
    check_eq("b_e_rt", b_ert, m_ert[1]);
    check_eq("b_e_ext", b_eext, m_eext[1]);
    check_eq("b_e_link", b_elink, m_elink[1]);
    check_eq("b_e_bt", 64'(b_ebt), 64'(m_ebt[1]));
    check_eq("b_taken", 64'(b_tc), 64'(m_tc[1]));
    check_eq("b_stall", 64'(b_sc), 64'(m_sc[1]));
  endtask

  task automatic do_reset();
    reset = 1'b1; stall = 1'b0; e_flush = 1'b0;
    step();
    reset = 1'b0;
  endtask

  function automatic logic [63:0] rand_val();
    case ($urandom_range(0, 5))
      0: return 64'h0;
      1: return {$urandom(), $urandom()};
      2: return 64'(-longint'($urandom_range(1, 5)));
      3: return 64'($urandom_range(1, 5));
      4: return 64'h0000_0000_8000_0000;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  initial begin
    logic [5:0]  ops [15] = '{6'd4, 6'd5, 6'd6, 6'd7, 6'd1, 6'd2, 6'd3, 6'd0,
                              6'd12, 6'd13, 6'd14, 6'd15, 6'd8, 6'd35, 6'd43};
    logic [31:0] ins;
    int          tc_before, sc_before;
    f_pc = '0; d_pc = '0; d_ins = '0; rs_fw = '0; rt_fw = '0;
    do_reset();
    check_eq("reset_e_ins", 64'(a_eins), 64'h0);
    check_eq("reset_taken", 64'(a_tc), 64'h0);

    // beq taken with delay slot
    d_pc = 64'h3000; f_pc = 64'h3004; d_ins = {6'b000100, 5'd1, 5'd2, 16'h0004};
    rs_fw = 64'd5; rt_fw = 64'd5;
    step();
    check_eq("beq_npc", 64'(a_npc), 64'h3014);
    check_eq("beq_fflush", 64'(a_ff), 64'h0);
    check_eq("beq_taken", 64'(a_tc), 64'h1);
    check_eq("beq_ebt", 64'(a_ebt), 64'h1);

    // bltz on the full 64-bit value
    d_ins = {6'b000001, 5'd3, 5'd0, 16'h0010};
    rs_fw = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    check_eq("bltz_neg", 64'(b_bt), 64'h1);
    rs_fw = 64'h0000_0000_8000_0000;
    step();
    check_eq("bltz_pos64", 64'(b_bt), 64'h0);
    check_eq("bltz_pos64_npc", b_npc, 64'h3008);

    // bne held by two stall cycles, then released
    do_reset();
    d_pc = 64'h5000; f_pc = 64'h5004; d_ins = {6'b000101, 5'd1, 5'd2, 16'h0010};
    rs_fw = 64'd1; rt_fw = 64'd2; stall = 1'b1;
    step();
    check_eq("bne_stall_npc", 64'(a_npc), 64'h5004);
    check_eq("bne_bubble", 64'(a_eins), 64'h0);
    step();
    check_eq("bne_stall_cnt", 64'(a_sc), 64'h2);
    check_eq("bne_no_taken", 64'(a_tc), 64'h0);
    stall = 1'b0;
    step();
    check_eq("bne_npc", 64'(a_npc), 64'h5044);
    check_eq("bne_taken", 64'(a_tc), 64'h1);

    // jal link address in both delay-slot modes
    d_pc = 64'h4000; f_pc = 64'h4004; d_ins = {6'b000011, 26'h0000100};
    step();
    check_eq("jal_link_ds1", 64'(a_elink), 64'h4008);
    check_eq("jal_ff_ds1", 64'(a_ff), 64'h0);
    check_eq("jal_link_ds0", b_elink, 64'h4004);
    check_eq("jal_ff_ds0", 64'(b_ff), 64'h1);

    // jr with e_flush and stall together
    tc_before = int'(a_tc); sc_before = int'(a_sc);
    d_ins = {6'b000000, 5'd4, 15'd0, 6'b001000}; rs_fw = 64'h3040;
    stall = 1'b1; e_flush = 1'b1;
    step();
    check_eq("jr_npc", 64'(a_npc), 64'h4004);
    check_eq("jr_bubble", 64'(b_eins), 64'h0);
    check_eq("jr_stall_inc", 64'(a_sc), 64'(sc_before + 1));
    check_eq("jr_taken_hold", 64'(a_tc), 64'(tc_before));
    stall = 1'b0; e_flush = 1'b0;

    // 20 consecutive jumps saturate the 4-bit counter
    do_reset();
    d_ins = {6'b000010, 26'h0000040};
    for (int k = 0; k < 20; k++) step();
    check_eq("sat_taken_b", 64'(b_tc), 64'd15);
    check_eq("sat_taken_a", 64'(a_tc), 64'd20);
    do_reset();
    check_eq("sat_reset_b", 64'(b_tc), 64'd0);

    // lui sign extension at 64 bits
    d_ins = {6'b001111, 5'd0, 5'd3, 16'h8000};
    step();
    check_eq("lui_ext64", b_eext, 64'hFFFF_FFFF_8000_0000);
    check_eq("lui_ext32", 64'(a_eext), 64'h8000_0000);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      ins = $urandom();
      ins[31:26] = ops[$urandom_range(0, 14)];
      if (ins[31:26] == 6'd1) ins[20:16] = 5'($urandom_range(0, 2));
      if (ins[31:26] == 6'd0) ins[5:0] = ($urandom_range(0, 2) == 0) ? 6'd32 :
                                         (($urandom_range(0, 1) == 0) ? 6'd8 : 6'd9);
      d_ins   = ins;
      d_pc    = {$urandom(), $urandom()} & ~64'h3;
      f_pc    = d_pc + 64'd4;
      rs_fw   = rand_val();
      rt_fw   = ($urandom_range(0, 3) == 0) ? rs_fw : rand_val();
      stall   = ($urandom_range(0, 4) == 0);
      e_flush = ($urandom_range(0, 9) == 0);
      reset   = ($urandom_range(0, 29) == 0);
      step();
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
